// File: rtl/apb_reg_pkg.sv
// Shared constants, register map and handshake state type for the APB register slave.
package apb_reg_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned OFS_W  = 5;
    localparam int unsigned WCNT_W = 4;
    localparam int unsigned IRQ_W  = 8;

    localparam logic [OFS_W-1:0] CTRL_OFS     = 5'h00;
    localparam logic [OFS_W-1:0] STATUS_OFS   = 5'h04;
    localparam logic [OFS_W-1:0] SCRATCH_OFS  = 5'h08;
    localparam logic [OFS_W-1:0] INT_STAT_OFS = 5'h0C;
    localparam logic [OFS_W-1:0] COUNT_OFS    = 5'h10;

    localparam logic [DATA_W-1:0] CTRL_RST_VAL    = 32'h0000_0000;
    localparam logic [DATA_W-1:0] SCRATCH_RST_VAL = 32'hA5A5_A5A5;
    localparam logic [IRQ_W-1:0]  INT_RST_VAL     = 8'h00;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_CLR_BIT  = 1;
    localparam int unsigned CTRL_MASK_LSB = 8;
    localparam int unsigned CTRL_MASK_MSB = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

    // Byte-lane merge: lane k of new_v replaces old_v only where strb[k] is set.
    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_v,
                                                      input logic [DATA_W-1:0] new_v,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int k = 0; k < int'(STRB_W); k++) begin
            if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB4 bus bundle between the requester and the register slave.
interface apb_reg_slave_if;
    import apb_reg_pkg::*;

    logic [ADDR_W-1:0] PADDR;
    logic              PSELx;
    logic              PENABLE;
    logic [STRB_W-1:0] PSTRB;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (output PADDR, PSELx, PENABLE, PSTRB, PWRITE, PWDATA,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PADDR, PSELx, PENABLE, PSTRB, PWRITE, PWDATA,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_slave_fsm.sv
// APB handshake sequencer: wait-state counting, registered PREADY, sample and commit strobes.
module apb_slave_fsm
    import apb_reg_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic psel_i,
    input  logic penable_i,
    output logic pready_o,
    output logic sample_c_o,
    output logic commit_c_o
);

    apb_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              pready_q, pready_d;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            pready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            pready_q <= pready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        commit_c_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    if (WAIT_STATES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                        wcnt_d  = WCNT_W'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q - WCNT_W'(1);
                if (!psel_i) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Completion edge; a dropped select or a fresh setup phase cancels the write.
                state_d    = IDLE;
                commit_c_o = psel_i && penable_i;
            end
            default: state_d = IDLE;
        endcase
        sample_c_o = (state_d == DONE);
        pready_d   = (state_d == DONE);
    end

    assign pready_o = pready_q;

endmodule

// File: rtl/apb_reg_slave.sv
// APB4 completer with CTRL/STATUS/SCRATCH/INT_STAT/COUNT bank, lane merging and error decode.
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter int unsigned       WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] CNT_RST     = 32'h0000_0000
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    apb_reg_slave_if.slave     bus,
    input  logic [DATA_W-1:0]  status_i,
    input  logic [IRQ_W-1:0]   irq_set_i,
    output logic [DATA_W-1:0]  ctrl_o,
    output logic               irq_o
);

    logic              pready, sample_c, commit_c;
    logic [OFS_W-1:0]  ofs;
    logic              err_c, wr_c, cnt_clr_c;
    logic [DATA_W-1:0] rdata_c;
    logic [DATA_W-1:0] ctrl_q, ctrl_d, scratch_q, scratch_d, count_q, count_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [IRQ_W-1:0]  int_q, int_d;
    logic              pslverr_q, pslverr_d, irq_q, irq_d;
    logic              unused_paddr_hi;

    apb_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .psel_i     (bus.PSELx),
        .penable_i  (bus.PENABLE),
        .pready_o   (pready),
        .sample_c_o (sample_c),
        .commit_c_o (commit_c)
    );

    assign ofs             = bus.PADDR[OFS_W-1:0];
    assign unused_paddr_hi = ^bus.PADDR[ADDR_W-1:OFS_W];

    // Decode: out-of-map, misaligned, or write to a read-only register.
    always_comb begin
        err_c = (ofs > COUNT_OFS) || (ofs[1:0] != 2'b00) ||
                (bus.PWRITE && ((ofs == STATUS_OFS) || (ofs == COUNT_OFS)));
        unique case (ofs)
            CTRL_OFS:     rdata_c = ctrl_q;
            STATUS_OFS:   rdata_c = status_i;
            SCRATCH_OFS:  rdata_c = scratch_q;
            INT_STAT_OFS: rdata_c = {(DATA_W-IRQ_W)'(0), int_q};
            COUNT_OFS:    rdata_c = count_q;
            default:      rdata_c = '0;
        endcase
    end

    assign wr_c = commit_c && bus.PWRITE && !err_c;

    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        int_d     = int_q | irq_set_i;
        cnt_clr_c = 1'b0;
        if (wr_c) begin
            case (ofs)
                CTRL_OFS: begin
                    ctrl_d    = merge_lanes(ctrl_q, bus.PWDATA, bus.PSTRB);
                    cnt_clr_c = bus.PSTRB[0] && bus.PWDATA[CTRL_CLR_BIT];
                end
                SCRATCH_OFS:  scratch_d = merge_lanes(scratch_q, bus.PWDATA, bus.PSTRB);
                // A coincident set pulse outranks the clear.
                INT_STAT_OFS: if (bus.PSTRB[0]) int_d = (int_q & ~bus.PWDATA[IRQ_W-1:0]) | irq_set_i;
                default: ;
            endcase
        end
        ctrl_d[CTRL_CLR_BIT] = 1'b0;
        count_d   = cnt_clr_c ? CNT_RST
                  : (ctrl_q[CTRL_EN_BIT] ? count_q + DATA_W'(1) : count_q);
        irq_d     = |(int_d & ctrl_d[CTRL_MASK_MSB:CTRL_MASK_LSB]);
        prdata_d  = (sample_c && !bus.PWRITE && !err_c) ? rdata_c : '0;
        pslverr_d = sample_c && err_c;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_q    <= CTRL_RST_VAL;
            scratch_q <= SCRATCH_RST_VAL;
            int_q     <= INT_RST_VAL;
            count_q   <= CNT_RST;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            scratch_q <= scratch_d;
            int_q     <= int_d;
            count_q   <= count_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.PRDATA  = prdata_q;
    assign bus.PSLVERR = pslverr_q;
    assign bus.PREADY  = pready;
    assign ctrl_o      = ctrl_q;
    assign irq_o       = irq_q;

endmodule
